// File: rtl/sdram_requester.sv
// sdram_requester: slot-aligned initiator for the 32 MHz SDRAM controller.
// Generates sync, schedules refresh/access/idle slots, serves one client.
// Ports: clk, reset_n (async, active low), ram_ready;
//   controller side: sync, refresh, cs, we, addr, ds, din, dout;
//   client side: req, req_we, req_addr, req_ds, req_din, ack, rdata.
// Optional macro SDRAM_REQUESTER_IDLE_REFRESH_EN: refresh early in idle slots
// once the refresh counter has reached REFRESH_SLOTS/2.
module sdram_requester #(
    parameter int SLOT_LEN      = 8,
    parameter int DOUT_SAMPLE   = 6,
    parameter int REFRESH_SLOTS = 30
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ram_ready,
    output logic        sync,
    output logic        refresh,
    output logic        cs,
    output logic        we,
    output logic [21:0] addr,
    output logic [1:0]  ds,
    output logic [15:0] din,
    input  logic [15:0] dout,
    input  logic        req,
    input  logic        req_we,
    input  logic [21:0] req_addr,
    input  logic [1:0]  req_ds,
    input  logic [15:0] req_din,
    output logic        ack,
    output logic [15:0] rdata
);

    localparam int CW = $clog2(SLOT_LEN);
    localparam int RW = $clog2(REFRESH_SLOTS + 1);

    localparam logic [CW-1:0] CNT_LAST   = CW'(SLOT_LEN - 1);
    localparam logic [CW-1:0] CNT_SYNC   = CW'(SLOT_LEN / 2 - 1);
    localparam logic [CW-1:0] CNT_SAMPLE = CW'(DOUT_SAMPLE);
    localparam logic [RW-1:0] RC_MAX     = RW'(REFRESH_SLOTS - 1);
`ifdef SDRAM_REQUESTER_IDLE_REFRESH_EN
    localparam logic [RW-1:0] RC_HALF    = RW'(REFRESH_SLOTS / 2);
`endif

    // ST_STOP: no slot active (before ram_ready, or after it fell)
    typedef enum logic [1:0] {
        ST_STOP,
        ST_IDLE,
        ST_ACCESS,
        ST_REFRESH
    } state_t;

    state_t        state;
    state_t        pick;
    logic [CW-1:0] slot_cnt;
    logic [RW-1:0] ref_cnt;

    // Kind of the next slot; only used at a slot boundary.
    // ack high means the client is still showing the finished request.
    always_comb begin
        pick = ST_IDLE;
        if (ref_cnt >= RC_MAX) begin
            pick = ST_REFRESH;
        end
`ifdef SDRAM_REQUESTER_IDLE_REFRESH_EN
        else if (!req && ref_cnt >= RC_HALF) begin
            pick = ST_REFRESH;
        end
`endif
        else if (req && !ack) begin
            pick = ST_ACCESS;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_STOP;
            slot_cnt <= '0;
            ref_cnt  <= '0;
            sync     <= 1'b0;
            refresh  <= 1'b0;
            cs       <= 1'b0;
            we       <= 1'b0;
            addr     <= '0;
            ds       <= '0;
            din      <= '0;
            ack      <= 1'b0;
            rdata    <= '0;
        end else begin
            ack <= 1'b0;
            if (state == ST_ACCESS && slot_cnt == CNT_SAMPLE) begin
                ack <= 1'b1;
                if (!we) begin
                    rdata <= dout;
                end
            end

            if (state == ST_STOP || slot_cnt == CNT_LAST) begin
                slot_cnt <= '0;
                if (ram_ready) begin
                    state   <= pick;
                    sync    <= 1'b1;
                    cs      <= (pick != ST_IDLE);
                    refresh <= (pick == ST_REFRESH);
                    if (pick == ST_ACCESS) begin
                        we   <= req_we;
                        addr <= req_addr;
                        ds   <= req_ds;
                        din  <= req_din;
                    end else begin
                        we   <= 1'b0;
                        addr <= '0;
                        ds   <= '0;
                        din  <= '0;
                    end
                    if (pick == ST_REFRESH) begin
                        ref_cnt <= '0;
                    end else if (ref_cnt != RC_MAX) begin
                        ref_cnt <= ref_cnt + RW'(1);
                    end
                end else begin
                    state   <= ST_STOP;
                    sync    <= 1'b0;
                    cs      <= 1'b0;
                    refresh <= 1'b0;
                    we      <= 1'b0;
                    addr    <= '0;
                    ds      <= '0;
                    din     <= '0;
                end
            end else begin
                slot_cnt <= slot_cnt + CW'(1);
                // sync covers the first half of the slot
                sync     <= (slot_cnt < CNT_SYNC);
            end
        end
    end

endmodule
